// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: FSM state encoding, byte-lane constants, and the helper that
// expands a 4-bit byte enable into a 32-bit bit mask.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam int         BYTE_W  = 8;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset (clears the read register only)
//   en_i      access strobe; one write and/or read happens on this edge
//   we_i      write the masked data at idx_i
//   be_i      byte enables for the write
//   idx_i     word index
//   wdata_i   write data
//   zero_i    load zero into the read register instead of the word
//   rdata_o   registered read data, held between accesses
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic             zero_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] wmask;

    assign wmask = be_to_mask(be_i);

    // Storage contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= (mem_q[idx_i] & ~wmask) | (wdata_i & wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= zero_i ? 32'h0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time on a valid/ready
// request channel, waits LATENCY cycles, commits to the internal array and
// presents the result on a valid/ready response channel.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_we, req_addr, req_wdata, req_be  request payload (byte address)
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                load data (0 for stores), fault flag
// Build option: DMEM_ERR_CHECK_EN enables range/alignment fault detection;
// without it rsp_err is 0 and the word index wraps modulo DEPTH_WORDS.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states after acceptance
// RESP  | response presented, waiting for rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             err_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;

    logic             accept;
    logic             commit;
    logic [31:0]      offset;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;

    logic             c_we;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign offset  = req_addr - BASE_ADDR;
    assign req_idx = offset[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    logic out_of_range;
    logic align_ok;
    assign out_of_range = (offset >> 2) >= 32'(DEPTH_WORDS);
    assign align_ok     = (req_addr[1:0] == 2'd0)
                       || (req_be == 4'b1100 && req_addr[1:0] == 2'd2)
                       || (req_be == (4'b0001 << req_addr[1:0]));
    assign req_err      = out_of_range || (req_we && !align_ok);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{offset[31:IDX_W+2], offset[1:0]};
    assign req_err          = 1'b0;
`endif

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the array must see the live request rather than the captured copy.
    assign c_we    = (LATENCY == 0) ? req_we    : we_q;
    assign c_idx   = (LATENCY == 0) ? req_idx   : idx_q;
    assign c_wdata = (LATENCY == 0) ? req_wdata : wdata_q;
    assign c_be    = (LATENCY == 0) ? req_be    : be_q;
    assign c_err   = (LATENCY == 0) ? req_err   : err_q;

    // Gated by rst so an aborted store never reaches the array.
    assign commit = !rst && (((state_q == IDLE) && accept && (LATENCY == 0))
                          || ((state_q == WAIT) && (cnt_q == 4'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        idx_q   <= req_idx;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= req_err;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (commit),
        .we_i    (c_we && !c_err),
        .be_i    (c_be),
        .idx_i   (c_idx),
        .wdata_i (c_wdata),
        .zero_i  (c_we || c_err),
        .rdata_o (rsp_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port, serving load/store requests through a valid/ready request channel and a valid/ready response channel.
- Adds configurable wait states, byte-enabled writes, and error signalling so the core can later move from a zero-latency memory to a multi-cycle, stallable one.
- Sits between the core's load/store path and a word-addressed storage array held inside the block.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array; must be a power of two.
- LATENCY, 2: wait states between request acceptance and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address that maps to word 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  request was faulty (see Optional Feature).

Behaviour:
- FSM has three states: IDLE, WAIT, RESP. Reset sets state IDLE and clears the wait counter, rsp_valid, rsp_rdata and rsp_err. Storage contents are not reset.
- req_ready = (state==IDLE) && !rst. Combinational, so it is low during any reset cycle.
- Request acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - On acceptance the block captures we, addr, wdata and be.
  - Next state is WAIT with counter = LATENCY-1, or RESP directly when LATENCY==0.
- WAIT: counter decrements once per cycle. When the counter is 0, the next state is RESP.
- Commit on the edge entering RESP:
  - Store: bytes with be=1 are written; other bytes are unchanged.
  - Load: the word is read into rsp_rdata.
  - rsp_valid is set.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready.
  - On that edge rsp_valid clears and state returns to IDLE.
  - req_ready rises the following cycle. There is no request/response overlap, so at most one transaction is outstanding.
- Word index = (req_addr - BASE_ADDR) >> 2. The low 2 address bits are ignored for indexing.
- A store with be=4'b0000 completes normally with no write.
- Read-after-write: a load issued after a store's response sees the stored data.
- Request inputs are ignored outside IDLE. The requester must hold its request stable while req_valid is high and req_ready is low.
- rst asserted in WAIT or RESP:
  - The transaction is aborted and state returns to IDLE.
  - A store that had not yet reached the RESP commit edge is not written.
  - No response is produced.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined:
  - A request is faulty if (addr - BASE_ADDR) >= 4*DEPTH_WORDS.
  - A store is also faulty if it is misaligned for its enables: any be with addr[1:0] != 0, except be=4'b1100 with addr[1:0]==2, and single-byte enables matching addr[1:0].
  - A faulty request gets rsp_err=1 and rsp_rdata=0, performs no write, and uses the same timing as a good request.
- Not defined: rsp_err is tied to 0 and the word index wraps modulo DEPTH_WORDS.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enumeration (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the BE_WORD constant (4'b1111) and byte-lane width constant (8);
  - the function computing the byte-lane write mask from be.
- One sub-module is natural: dmem_array, a synchronous-write, registered-read word array with per-byte write enables, sized by DEPTH_WORDS. The FSM, counter and error logic live in dmem_responder.

Test Plan:
- Store then load, LATENCY=2: store 32'hDEAD_BEEF to 0x10 with be=4'hF, then load 0x10 → rsp_valid rises 3 cycles after each acceptance; rsp_rdata=32'hDEAD_BEEF; rsp_err=0.
- Partial store: pre-write 0x20=32'h1122_3344, then store 32'hAABB_CCDD with be=4'b0101, then load 0x20 → rsp_rdata=32'h11BB_33DD.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load of 0x10 → rsp_valid and rsp_rdata stay stable; req_ready stays 0; acceptance of a new request happens only after the handshake completes.
- LATENCY=0 build, back-to-back loads with rsp_ready=1 → response one cycle after acceptance; a new request is accepted every 2 cycles.
- Reset mid-WAIT: accept a store of 32'h0000_0055 to 0x30, assert rst in cycle 1 of WAIT → no rsp_valid; a later load of 0x30 returns its prior value.
- Error path (DMEM_ERR_CHECK_EN defined, DEPTH_WORDS=1024): store to 0x1000 → rsp_err=1 with no write; load 0x0 → rsp_err=0. Undefined-macro build, load 0x1000 → returns the contents of word 0.
